regfile_rename_ckpt: RTL and testbench

Architectural register file plus rename (dependency) table for the out-of-order core, with a configurable number of read ports and a bank of branch checkpoints. It sits between decoder (source lookup, destination rename), ROB (commit write-back, value forwarding) and branch unit (checkpoint take/restore). A mispredict rolls the rename table back in one cycle instead of waiting for a full `clear`.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_ckpt_slot.sv | 37 +++
 rtl/regfile_rename_ckpt.sv | 141 ++++++++++++++
 tb/tb_regfile_rename_ckpt.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the register file / rename table and its checkpoint slots.
package rf_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_W      = $clog2(NUM_REGS);
    localparam int ROB_W      = 4;
    localparam int MAX_CKPT   = 16;
    localparam int MAX_CKPT_W = $clog2(MAX_CKPT);

    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] tag;
    } rn_entry_t;

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [MAX_CKPT_W-1:0] lowest_free(input logic [MAX_CKPT-1:0] free);
        lowest_free = '0;
        for (int i = MAX_CKPT - 1; i >= 0; i--) begin
            if (free[i]) lowest_free = MAX_CKPT_W'(i);
        end
    endfunction

endpackage

// File: rtl/rf_ckpt_slot.sv
// One branch checkpoint: a snapshot of the rename table plus its valid bit.
module rf_ckpt_slot import rf_pkg::*; (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clear,
    input  logic                      load,
    input  rn_entry_t [NUM_REGS-1:0]  load_data,
    input  logic                      cm_en,
    input  logic [REG_W-1:0]          cm_rd,
    input  logic [ROB_W-1:0]          cm_tag,
    input  logic                      free,
    output logic                      valid,
    output logic                      valid_next,
    output rn_entry_t [NUM_REGS-1:0]  snap
);

    // A free landing on the slot being loaded wins, so a released slot is retaken a cycle later.
    assign valid_next = clear ? 1'b0 : ((valid | load) & ~free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  valid <= 1'b0;
        else if (en) valid <= valid_next;
    end

    // NOTE: the snapshot array has no reset; nothing reads it unless valid is set.
    always_ff @(posedge clk) begin
        if (en && !clear) begin
            if (load) begin
                snap <= load_data;
            end else if (cm_en && snap[cm_rd].tag == cm_tag) begin
                snap[cm_rd].busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_rename_ckpt.sv
// Architectural register file with rename table, bypassing read ports and branch checkpoints.
// Register count and ROB tag width come from rf_pkg so the rename entry type stays consistent.
module regfile_rename_ckpt import rf_pkg::*; #(
    parameter int  NUM_RD   = 2,
    parameter int  NUM_CKPT = 4,
    localparam int CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic                      clear,
    input  logic                      cm_valid,
    input  logic [REG_W-1:0]          cm_rd,
    input  logic [ROB_W-1:0]          cm_tag,
    input  logic [31:0]               cm_val,
    input  logic                      rn_valid,
    input  logic [REG_W-1:0]          rn_rd,
    input  logic [ROB_W-1:0]          rn_tag,
    input  logic [NUM_RD*REG_W-1:0]   rd_id,
    output logic [NUM_RD-1:0]         rd_busy,
    output logic [NUM_RD*ROB_W-1:0]   rd_tag,
    output logic [NUM_RD*32-1:0]      rd_val,
    output logic [NUM_RD*ROB_W-1:0]   rob_q_tag,
    input  logic [NUM_RD-1:0]         rob_q_ready,
    input  logic [NUM_RD*32-1:0]      rob_q_val,
    input  logic                      ck_take,
    output logic                      ck_ready,
    output logic [CKPT_W-1:0]         ck_id,
    input  logic                      ck_restore,
    input  logic [CKPT_W-1:0]         ck_restore_id,
    input  logic [NUM_CKPT-1:0]       ck_free_mask,
    output logic [CKPT_W:0]           ck_count
);

    logic [31:0]              regs [NUM_REGS];
    rn_entry_t [NUM_REGS-1:0] live, live_next;
    rn_entry_t [NUM_REGS-1:0] slot_snap [NUM_CKPT];
    logic [NUM_CKPT-1:0]      slot_valid, slot_valid_next, slot_load, slot_free;
    logic [CKPT_W:0]          count, count_next;
    logic                     cm_en, rn_en, restore_hit, take_acc;

    assign cm_en       = cm_valid && (cm_rd != '0);
    assign rn_en       = rn_valid && (rn_rd != '0);
    assign restore_hit = ck_restore && (int'(ck_restore_id) < NUM_CKPT) && slot_valid[ck_restore_id];

    assign ck_ready = |(~slot_valid);
    assign ck_id    = CKPT_W'(lowest_free(MAX_CKPT'(~slot_valid)));
    assign take_acc = ck_take && ck_ready && rdy && !clear && !restore_hit;
    assign ck_count = count;

    // NOTE: combinational blocks use blocking assignments and start from a full default, so no latch is inferred.
    always_comb begin
        live_next = live;
        if (clear) begin
            live_next = '0;
        end else if (restore_hit) begin
            live_next = slot_snap[ck_restore_id];
            if (cm_en && live_next[cm_rd].tag == cm_tag) live_next[cm_rd].busy = 1'b0;
        end else begin
            if (cm_en && live[cm_rd].tag == cm_tag && !(rn_en && rn_rd == cm_rd))
                live_next[cm_rd].busy = 1'b0;
            if (rn_en) live_next[rn_rd] = '{busy: 1'b1, tag: rn_tag};
        end
    end

    for (genvar s = 0; s < NUM_CKPT; s++) begin : g_slot
        assign slot_load[s] = take_acc && (ck_id == CKPT_W'(s));
        assign slot_free[s] = ck_free_mask[s] || (restore_hit && ck_restore_id == CKPT_W'(s));

        rf_ckpt_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (rdy),
            .clear      (clear),
            .load       (slot_load[s]),
            .load_data  (live_next),
            .cm_en      (cm_en),
            .cm_rd      (cm_rd),
            .cm_tag     (cm_tag),
            .free       (slot_free[s]),
            .valid      (slot_valid[s]),
            .valid_next (slot_valid_next[s]),
            .snap       (slot_snap[s])
        );
    end

    always_comb begin
        count_next = '0;
        for (int s = 0; s < NUM_CKPT; s++) count_next = count_next + (CKPT_W+1)'(slot_valid_next[s]);
    end

    // NOTE: the value array is reset because every register must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live  <= '0;
            count <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (rdy) begin
            live  <= live_next;
            count <= count_next;
            if (cm_en) regs[cm_rd] <= cm_val;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [REG_W-1:0] r;
        logic             busy_o;
        logic [ROB_W-1:0] tag_o;
        logic [31:0]      val_o;

        always_comb begin
            r      = rd_id[p*REG_W +: REG_W];
            busy_o = 1'b0;
            tag_o  = '0;
            val_o  = '0;
            if (r != '0) begin
                if (rn_valid && rn_rd == r) begin
                    busy_o = 1'b1;
                    tag_o  = rn_tag;
                    val_o  = regs[r];
                end else if (cm_valid && cm_rd == r && live[r].busy && live[r].tag == cm_tag) begin
                    tag_o  = live[r].tag;
                    val_o  = cm_val;
                end else if (live[r].busy) begin
                    busy_o = !rob_q_ready[p];
                    tag_o  = live[r].tag;
                    val_o  = rob_q_val[p*32 +: 32];
                end else begin
                    tag_o  = live[r].tag;
                    val_o  = regs[r];
                end
            end
        end

        assign rd_busy[p]              = busy_o;
        assign rd_tag[p*ROB_W +: ROB_W] = tag_o;
        assign rob_q_tag[p*ROB_W +: ROB_W] = tag_o;
        assign rd_val[p*32 +: 32]      = val_o;
    end

endmodule

// File: tb/tb_regfile_rename_ckpt.sv
// Scoreboard bench for regfile_rename_ckpt: expectations queued with stimulus, compared on sampling.
module tb_regfile_rename_ckpt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy, clear;
    logic        cm_valid;
    logic [4:0]  cm_rd;
    logic [3:0]  cm_tag;
    logic [31:0] cm_val;
    logic        rn_valid;
    logic [4:0]  rn_rd;
    logic [3:0]  rn_tag;
    logic [9:0]  rd_id;
    logic [1:0]  rd_busy;
    logic [7:0]  rd_tag;
    logic [63:0] rd_val;
    logic [7:0]  rob_q_tag;
    logic [1:0]  rob_q_ready;
    logic [63:0] rob_q_val;
    logic        ck_take, ck_ready;
    logic [1:0]  ck_id;
    logic        ck_restore;
    logic [1:0]  ck_restore_id;
    logic [3:0]  ck_free_mask;
    logic [2:0]  ck_count;

    regfile_rename_ckpt #(.NUM_RD(2), .NUM_CKPT(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
        .rn_valid(rn_valid), .rn_rd(rn_rd), .rn_tag(rn_tag),
        .rd_id(rd_id), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_val(rd_val),
        .rob_q_tag(rob_q_tag), .rob_q_ready(rob_q_ready), .rob_q_val(rob_q_val),
        .ck_take(ck_take), .ck_ready(ck_ready), .ck_id(ck_id),
        .ck_restore(ck_restore), .ck_restore_id(ck_restore_id),
        .ck_free_mask(ck_free_mask), .ck_count(ck_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs[$];
    int          checks = 0;
    int          failures = 0;

    function automatic void exp_push(string n, logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] p_busy(int p); return 32'(rd_busy[p]);        endfunction
    function automatic logic [31:0] p_tag(int p);  return 32'(rd_tag[p*4 +: 4]);  endfunction
    function automatic logic [31:0] p_qtag(int p); return 32'(rob_q_tag[p*4 +: 4]); endfunction
    function automatic logic [31:0] p_val(int p);  return rd_val[p*32 +: 32];     endfunction

    task automatic set_rd(int p, logic [4:0] r);
        rd_id[p*5 +: 5] = r;
    endtask

    task automatic idle();
        rdy = 1'b1; clear = 1'b0;
        cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_val = '0;
        rn_valid = 1'b0; rn_rd = '0; rn_tag = '0;
        rob_q_ready = '0; rob_q_val = {32'hBAD0_0001, 32'hBAD0_0000};
        ck_take = 1'b0; ck_restore = 1'b0; ck_restore_id = '0; ck_free_mask = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        set_rd(0, 5'd5); set_rd(1, 5'd0);
        rn_valid = 1'b1; rn_rd = 5'd0; rn_tag = 4'd3;
        exp_push("rst x5 busy", 0);  exp_push("rst x5 val", 0);
        exp_push("rst x0 busy", 0);  exp_push("rst x0 val", 0);
        exp_push("rst ck_ready", 1); exp_push("rst ck_id", 0); exp_push("rst ck_count", 0);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_val(0));
        obs.push_back(p_busy(1)); obs.push_back(p_val(1));
        obs.push_back(32'(ck_ready)); obs.push_back(32'(ck_id)); obs.push_back(32'(ck_count));
        tick();
        idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[0] !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs[0], e.val);
            end
            void'(obs.pop_front());
        end
    endtask

    task automatic test_commit_bypass();
        exp_t e;
        idle();
        set_rd(0, 5'd5);
        rn_valid = 1'b1; rn_rd = 5'd5; rn_tag = 4'd3;
        exp_push("rn bypass busy", 1); exp_push("rn bypass tag", 3); exp_push("rn bypass qtag", 3);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_tag(0)); obs.push_back(p_qtag(0));
        tick(); idle();
        cm_valid = 1'b1; cm_rd = 5'd5; cm_tag = 4'd3; cm_val = 32'hDEAD;
        exp_push("cm bypass busy", 0); exp_push("cm bypass val", 32'hDEAD);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_val(0));
        tick(); idle();
        exp_push("x5 after commit busy", 0); exp_push("x5 after commit val", 32'hDEAD);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_val(0));
        rn_valid = 1'b1; rn_rd = 5'd6; rn_tag = 4'd5;
        tick(); idle();
        set_rd(1, 5'd6);
        exp_push("x6 pending busy", 1); exp_push("x6 pending tag", 5); exp_push("x6 rob_q_tag", 5);
        #1;
        obs.push_back(p_busy(1)); obs.push_back(p_tag(1)); obs.push_back(p_qtag(1));
        rob_q_ready = 2'b10; rob_q_val[63:32] = 32'h1234;
        exp_push("x6 rob ready busy", 0); exp_push("x6 rob value", 32'h1234);
        #1;
        obs.push_back(p_busy(1)); obs.push_back(p_val(1));
        idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[0] !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs[0], e.val);
            end
            void'(obs.pop_front());
        end
    endtask

    task automatic test_rename_commit_same();
        exp_t e;
        idle();
        rn_valid = 1'b1; rn_rd = 5'd7; rn_tag = 4'd2;
        cm_valid = 1'b1; cm_rd = 5'd7; cm_tag = 4'd1; cm_val = 32'h77;
        tick(); idle();
        set_rd(0, 5'd7);
        exp_push("x7 rename wins busy", 1); exp_push("x7 rename wins tag", 2);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_tag(0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[0] !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs[0], e.val);
            end
            void'(obs.pop_front());
        end
    endtask

    task automatic test_ckpt_restore();
        exp_t e;
        idle();
        ck_take = 1'b1;
        rn_valid = 1'b1; rn_rd = 5'd13; rn_tag = 4'd9;
        exp_push("take ck_ready", 1); exp_push("take ck_id", 0);
        #1;
        obs.push_back(32'(ck_ready)); obs.push_back(32'(ck_id));
        tick(); idle();
        exp_push("after take ck_count", 1);
        #1;
        obs.push_back(32'(ck_count));
        rn_valid = 1'b1; rn_rd = 5'd3; rn_tag = 4'd4;
        tick(); idle();
        set_rd(0, 5'd3);
        exp_push("x3 renamed busy", 1); exp_push("x3 renamed tag", 4);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_tag(0));
        rn_valid = 1'b1; rn_rd = 5'd8; rn_tag = 4'd6;
        tick(); idle();
        cm_valid = 1'b1; cm_rd = 5'd3; cm_tag = 4'd4; cm_val = 32'h33;
        ck_restore = 1'b1; ck_restore_id = 2'd0;
        rn_valid = 1'b1; rn_rd = 5'd9; rn_tag = 4'd1;
        ck_take = 1'b1;
        tick(); idle();
        set_rd(0, 5'd3); set_rd(1, 5'd8);
        exp_push("restore x3 busy", 0); exp_push("restore x3 val", 32'h33);
        exp_push("restore x8 busy", 0); exp_push("restore ck_count", 0); exp_push("restore ck_id", 0);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_val(0));
        obs.push_back(p_busy(1)); obs.push_back(32'(ck_count)); obs.push_back(32'(ck_id));
        set_rd(0, 5'd13); set_rd(1, 5'd9);
        exp_push("restore x13 busy", 1); exp_push("restore x13 tag", 9); exp_push("restore x9 busy", 0);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_tag(0)); obs.push_back(p_busy(1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[0] !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs[0], e.val);
            end
            void'(obs.pop_front());
        end
    endtask

    task automatic test_ckpt_full();
        exp_t e;
        idle();
        ck_take = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_push($sformatf("fill%0d ck_id", i), 32'(i)); exp_push($sformatf("fill%0d ck_ready", i), 1);
            #1;
            obs.push_back(32'(ck_id)); obs.push_back(32'(ck_ready));
            tick();
        end
        exp_push("full ck_ready", 0); exp_push("full ck_count", 4);
        #1;
        obs.push_back(32'(ck_ready)); obs.push_back(32'(ck_count));
        tick(); idle();
        exp_push("dropped take ck_count", 4);
        #1;
        obs.push_back(32'(ck_count));
        ck_free_mask = 4'b0100; ck_take = 1'b1;
        exp_push("free same cycle ck_ready", 0);
        #1;
        obs.push_back(32'(ck_ready));
        tick(); idle();
        exp_push("after free ck_ready", 1); exp_push("after free ck_id", 2); exp_push("after free ck_count", 3);
        #1;
        obs.push_back(32'(ck_ready)); obs.push_back(32'(ck_id)); obs.push_back(32'(ck_count));
        cm_valid = 1'b1; cm_rd = 5'd6; cm_tag = 4'd5; cm_val = 32'h66;
        tick(); idle();
        rn_valid = 1'b1; rn_rd = 5'd6; rn_tag = 4'd7;
        tick(); idle();
        set_rd(0, 5'd6);
        exp_push("x6 re-renamed busy", 1); exp_push("x6 re-renamed tag", 7);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_tag(0));
        ck_restore = 1'b1; ck_restore_id = 2'd3;
        tick(); idle();
        exp_push("slot commit-clear x6 busy", 0); exp_push("slot commit-clear x6 val", 32'h66);
        exp_push("restore3 ck_count", 2); exp_push("restore3 ck_id", 2);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_val(0));
        obs.push_back(32'(ck_count)); obs.push_back(32'(ck_id));
        rdy = 1'b0; rn_valid = 1'b1; rn_rd = 5'd20; rn_tag = 4'd1; ck_take = 1'b1;
        tick(); idle();
        set_rd(1, 5'd20);
        exp_push("rdy low x20 busy", 0); exp_push("rdy low ck_count", 2);
        #1;
        obs.push_back(p_busy(1)); obs.push_back(32'(ck_count));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[0] !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs[0], e.val);
            end
            void'(obs.pop_front());
        end
    endtask

    task automatic test_clear();
        exp_t e;
        idle();
        set_rd(0, 5'd7);
        exp_push("pre-clear x7 busy", 1);
        #1;
        obs.push_back(p_busy(0));
        clear = 1'b1; ck_restore = 1'b1; ck_restore_id = 2'd0; ck_take = 1'b1;
        rn_valid = 1'b1; rn_rd = 5'd11; rn_tag = 4'd3;
        cm_valid = 1'b1; cm_rd = 5'd9; cm_tag = 4'd0; cm_val = 32'h99;
        tick(); idle();
        set_rd(0, 5'd7); set_rd(1, 5'd9);
        exp_push("clear x7 busy", 0); exp_push("clear x7 val", 32'h77); exp_push("clear x9 val", 32'h99);
        exp_push("clear ck_count", 0); exp_push("clear ck_ready", 1); exp_push("clear ck_id", 0);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_val(0)); obs.push_back(p_val(1));
        obs.push_back(32'(ck_count)); obs.push_back(32'(ck_ready)); obs.push_back(32'(ck_id));
        set_rd(0, 5'd11); set_rd(1, 5'd6);
        exp_push("clear x11 busy", 0); exp_push("clear x6 busy", 0); exp_push("clear x6 val", 32'h66);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_busy(1)); obs.push_back(p_val(1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[0] !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs[0], e.val);
            end
            void'(obs.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        idle();
        rn_valid = 1'b1; rn_rd = 5'd12; rn_tag = 4'd1; ck_take = 1'b1;
        tick(); idle();
        set_rd(0, 5'd12); set_rd(1, 5'd7);
        exp_push("pre-reset x12 busy", 1); exp_push("pre-reset ck_count", 1);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(32'(ck_count));
        #1 rst_n = 1'b0;
        exp_push("mid reset x12 busy", 0); exp_push("mid reset x7 val", 0);
        exp_push("mid reset ck_count", 0); exp_push("mid reset ck_ready", 1); exp_push("mid reset ck_id", 0);
        #1;
        obs.push_back(p_busy(0)); obs.push_back(p_val(1));
        obs.push_back(32'(ck_count)); obs.push_back(32'(ck_ready)); obs.push_back(32'(ck_id));
        tick();
        rst_n = 1'b1;
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs[0] !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs[0], e.val);
            end
            void'(obs.pop_front());
        end
    endtask

    initial begin
        idle();
        rd_id = '0;
        #12 rst_n = 1'b1;
        tick();
        test_reset();
        test_commit_bypass();
        test_rename_commit_same();
        test_ckpt_restore();
        test_ckpt_full();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
